// File: rtl/nota_scroll_scheduler.sv
// nota_scroll_scheduler
//
// Queues newly detected notes and paces the left scroll of the note display so
// that every accepted note yields exactly STEPS scroll strobes, one per frame
// tick. Notes that arrive while a scroll is running wait in a small FIFO.
//
// Ports:
//   clock               system clock, rising edge
//   reset               synchronous, active-high; clears all state
//   notaActual          current decoded note (level, may hold many cycles)
//   tick                one-cycle frame-rate pacing strobe
//   movimientoIzquierda one-cycle scroll-left strobe to the display shifter
//   nota_out            note currently being scrolled, held until next pop
//   nota_load           one-cycle strobe: nota_out just took a new note
//   fifo_count          notes waiting in the FIFO (0..DEPTH)
//   overflow            sticky: a note was dropped on a full FIFO
module nota_scroll_scheduler #(
    parameter int unsigned THRESH = 14,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned STEPS  = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [5:0]             notaActual,
    input  logic                   tick,
    output logic                   movimientoIzquierda,
    output logic [5:0]             nota_out,
    output logic                   nota_load,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [5:0]    thresh_v  = 6'(THRESH);
    localparam logic [CW-1:0] depth_v   = CW'(DEPTH);
    localparam logic [7:0]    last_step = 8'(STEPS - 1);

    typedef enum logic {
        st_idle,
        st_shift
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    step_q, step_d;

    logic [5:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;

    logic [5:0]    last_note;
    logic          last_valid;

    logic          new_note, full, empty, pop, push, drop;

    logic          mov_d, load_d, overflow_d;
    logic [5:0]    nota_out_d;
    logic [CW-1:0] count_d;

    // Capture and FIFO handshake decode
    always_comb begin
        // A note counts as new only on a change of value, so a held level is
        // pushed (or dropped) once and never retried.
        new_note = (notaActual > thresh_v) && (!last_valid || (notaActual != last_note));
        full     = (fifo_count == depth_v);
        empty    = (fifo_count == '0);
        pop      = (state_q == st_idle) && !empty;
        // A same-edge pop frees a slot, so a push into a full FIFO still fits.
        push     = new_note && (!full || pop);
        drop     = new_note && full && !pop;
    end

    // Scroll FSM next state and registered-output next values
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        mov_d      = 1'b0;
        load_d     = 1'b0;
        nota_out_d = nota_out;

        case (state_q)
            st_idle: begin
                // tick is deliberately ignored here: strobes only belong to a note.
                if (pop) begin
                    nota_out_d = mem[rd_ptr];
                    load_d     = 1'b1;
                    step_d     = '0;
                    state_d    = st_shift;
                end
            end
            st_shift: begin
                if (tick) begin
                    mov_d  = 1'b1;
                    step_d = step_q + 8'd1;
                    if (step_q == last_step) begin
                        state_d = st_idle;
                    end
                end
            end
            default: state_d = st_idle;
        endcase
    end

    // Occupancy and sticky overflow
    always_comb begin
        count_d = fifo_count;
        if (push && !pop) begin
            count_d = fifo_count + CW'(1);
        end else if (pop && !push) begin
            count_d = fifo_count - CW'(1);
        end
        overflow_d = overflow | drop;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q             <= st_idle;
            step_q              <= '0;
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            last_note           <= '0;
            last_valid          <= 1'b0;
            movimientoIzquierda <= 1'b0;
            nota_load           <= 1'b0;
            nota_out            <= '0;
            fifo_count          <= '0;
            overflow            <= 1'b0;
        end else begin
            state_q             <= state_d;
            step_q              <= step_d;
            movimientoIzquierda <= mov_d;
            nota_load           <= load_d;
            nota_out            <= nota_out_d;
            fifo_count          <= count_d;
            overflow            <= overflow_d;
            if (new_note) begin
                last_note  <= notaActual;
                last_valid <= 1'b1;
            end
            // DEPTH is a power of two, so pointers wrap naturally.
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Storage needs no reset: occupancy and pointers define what is valid.
    always_ff @(posedge clock) begin
        if (!reset && push) begin
            mem[wr_ptr] <= notaActual;
        end
    end

endmodule
